// File: rtl/edge_sched_pkg.sv
// Shared constants, width helper and event payload for the edge event scheduler.
package edge_sched_pkg;

  localparam int unsigned EDGE_LANES_DEF = 8;
  localparam int unsigned OVF_CNT_W      = 16;

  // Lane-index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned EDGE_IDXW = idx_w(EDGE_LANES_DEF);

  typedef struct packed {
    logic [EDGE_IDXW-1:0] lane;
    logic                 rise;
  } edge_evt_t;

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at/after ptr, wrapping.
module rr_arbiter
  import edge_sched_pkg::*;
#(
  parameter  int unsigned N    = EDGE_LANES_DEF,
  localparam int unsigned IDXW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  int unsigned     scan_pos;
  logic [IDXW-1:0] scan_idx;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_pos = (32'(ptr) + k) % N;
      scan_idx = IDXW'(scan_pos);
      if (!gnt_valid && req[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Per-lane edge detector + pending latch + round-robin serialiser onto a
// single valid/ready event port. Define EDGE_OVF_CNT_EN to add the
// saturating overflow_cnt port counting clocks in which a pending lane merged.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter  int unsigned N    = EDGE_LANES_DEF,
  localparam int unsigned IDXW = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  input  logic                 enable,
  input  logic [N-1:0]         lane_mask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IDXW-1:0]      evt_lane,
  output logic                 evt_rise,
  output logic [N-1:0]         pending
`ifdef EDGE_OVF_CNT_EN
  ,output logic [OVF_CNT_W-1:0] overflow_cnt
`endif
);

  logic [N-1:0]    in_q;
  logic            primed_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    pol_q, pol_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  edge_evt_t       evt_q, evt_d;
  logic            evt_valid_q, evt_valid_d;

  logic [N-1:0]    edge_det, rise_det, set_req, gnt_mask;
  logic            slot_free;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;

  rr_arbiter #(.N(N)) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Edge detection is suppressed until in_q holds a real sample.
  always_comb begin
    edge_det = primed_q ? (in ^ in_q) : '0;
    rise_det = in & ~in_q;
    set_req  = edge_det & lane_mask & {N{enable}};
  end

  // Output slot reload, pending clear/set and pointer advance.
  always_comb begin
    slot_free   = !evt_valid_q || evt_ready;
    gnt_mask    = '0;
    evt_d       = evt_q;
    evt_valid_d = evt_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      evt_valid_d = gnt_valid;
      if (gnt_valid) begin
        gnt_mask[gnt_idx] = 1'b1;
        evt_d.lane        = EDGE_IDXW'(gnt_idx);
        evt_d.rise        = pol_q[gnt_idx];
        rr_ptr_d          = (gnt_idx == IDXW'(N - 1)) ? '0 : IDXW'(gnt_idx + 1'b1);
      end
    end
    // A new edge on the lane being granted re-arms it, so nothing is lost.
    pending_d = (pending_q & ~gnt_mask) | set_req;
    pol_d     = (pol_q & ~set_req) | (rise_det & set_req);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q        <= '0;
      primed_q    <= 1'b0;
      pending_q   <= '0;
      pol_q       <= '0;
      rr_ptr_q    <= '0;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      in_q        <= in;
      primed_q    <= 1'b1;
      pending_q   <= pending_d;
      pol_q       <= pol_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_lane  = IDXW'(evt_q.lane);
  assign evt_rise  = evt_q.rise;
  assign pending   = pending_q;

`ifdef EDGE_OVF_CNT_EN
  logic                 merge_any;
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  // A merge is a new edge on a lane still pending and not granted this clock.
  always_comb merge_any = |(set_req & pending_q & ~gnt_mask);

  // Saturating merge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (merge_any && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign overflow_cnt = ovf_cnt_q;
`endif

endmodule
